// File: rtl/msk_pkg.sv
// msk_pkg: helpers shared by the masked AND gadget files.
//   hpc2rnd(d)          fresh random bits one lane needs per operation (d*(d-1)/2)
//   pair_idx(i, j, d)   position of the random bit shared by share pair (i, j), i < j,
//                       inside one lane's randomness slice
//   share_base(l, d)    lowest bit of lane l in a lane-major sharing bus
//   rnd_base(l, d)      lowest bit of lane l in the randomness bus
package msk_pkg;

  function automatic int hpc2rnd(input int d);
    return (d * (d - 1)) / 2;
  endfunction

  // Pairs are enumerated row by row over the strict upper triangle:
  // (0,1) (0,2) .. (0,d-1) (1,2) .. (d-2,d-1).
  function automatic int pair_idx(input int i, input int j, input int d);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int share_base(input int lane, input int d);
    return lane * d;
  endfunction

  function automatic int rnd_base(input int lane, input int d);
    return lane * hpc2rnd(d);
  endfunction

endpackage

// File: rtl/msk_and_hpc2_lane.sv
// msk_and_hpc2_lane: one d-share HPC2 masked AND for a single bit.
//   clk  clock
//   en0  capture stage 0 (cycle where x and r are presented)
//   en1  capture stage 1 (cycle where y is presented)
//   x    latency-0 operand shares
//   y    latency-1 operand shares
//   r    fresh randomness, one bit per share pair
//   out  result shares, valid one cycle after the en1 capture
// CROSS=1 leaves out the inner-domain products x_i & y_i.
module msk_and_hpc2_lane
  import msk_pkg::*;
#(
  parameter int d     = 2,
  parameter int CROSS = 0
) (
  input  logic                  clk,
  input  logic                  en0,
  input  logic                  en1,
  input  logic [d-1:0]          x,
  input  logic [d-1:0]          y,
  input  logic [hpc2rnd(d)-1:0] r,
  output logic [d-1:0]          out
);

  // Symmetric view of the randomness: r_full[i][j] == r_full[j][i], zero diagonal.
  logic [d-1:0][d-1:0] r_full;
  logic [d-1:0][d-1:0] term;

  for (genvar i = 0; i < d; i++) begin : g_row
    for (genvar j = 0; j < d; j++) begin : g_col
      (* keep = "true" *) logic s_q;
      (* keep = "true" *) logic r_q;
      (* keep = "true" *) logic p_q;
      (* keep = "true" *) logic q_q;
      logic s_d;

      if (i == j) begin : g_diag
        assign r_full[i][j] = 1'b0;
        // Diagonal cell carries the inner-domain product: with r = 0 the
        // stage-1 terms reduce to y_i & x_i.
        assign s_d = (CROSS == 0) ? x[i] : 1'b0;
      end else begin : g_off
        if (i < j) begin : g_upper
          assign r_full[i][j] = r[pair_idx(i, j, d)];
        end else begin : g_lower
          assign r_full[i][j] = r[pair_idx(j, i, d)];
        end
        assign s_d = x[j] ^ r_full[i][j];
      end

      // Stage 0: masked cross term and its mask. Stage 1: the two products
      // are kept in separate registers so y_i never meets x_j ^ r and r in
      // the same combinational cone.
      always_ff @(posedge clk) begin
        if (en0) begin
          s_q <= s_d;
          r_q <= r_full[i][j];
        end
        if (en1) begin
          p_q <= ~y[i] & r_q;
          q_q <= y[i] & s_q;
        end
      end

      assign term[i][j] = p_q ^ q_q;
    end
  end

  // Share i only ever sums terms owned by share i.
  always_comb begin
    out = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        out[i] = out[i] ^ term[i][j];
      end
    end
  end

endmodule

// File: rtl/msk_and_hpc2_bus.sv
// msk_and_hpc2_bus: W parallel d-share HPC2 masked AND lanes, 2-cycle latency.
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   ina (inb when SWAP=1) presented this cycle
//   in_ready   an operation can be accepted this cycle
//   ina, inb   operand sharings, bit i share j at index i*d+j
//   rnd        fresh randomness, hpc2rnd(d) bits per lane
//   rnd_valid  rnd is fresh this cycle
//   out        result sharing, same layout
//   out_valid  out holds a result this cycle
//   op_count   results delivered since reset, wraps at 16 bits
// Handshake: an operation is accepted in any cycle where in_valid and
// in_ready are both high; in_ready mirrors rnd_valid and is low during rst.
// The latency-1 operand must follow on the very next cycle with no handshake
// of its own, and the result appears two cycles after the accept with no
// back-pressure, so one accept per cycle streams without stalls.
module msk_and_hpc2_bus
  import msk_pkg::*;
#(
  parameter int d     = 2,
  parameter int W     = 8,
  parameter int SWAP  = 0,
  parameter int CROSS = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W*d-1:0]          ina,
  input  logic [W*d-1:0]          inb,
  input  logic [W*hpc2rnd(d)-1:0] rnd,
  input  logic                    rnd_valid,
  output logic [W*d-1:0]          out,
  output logic                    out_valid,
  output logic [15:0]             op_count
);

  localparam int R = hpc2rnd(d);

  logic           accept;
  logic           v1;
  logic           v2;
  logic [W*d-1:0] op_x;
  logic [W*d-1:0] op_y;

  assign in_ready = rnd_valid & ~rst;
  assign accept   = in_valid & in_ready;

  // Port-level exchange only; lanes always see x first and y one cycle later.
  assign op_x = (SWAP != 0) ? inb : ina;
  assign op_y = (SWAP != 0) ? ina : inb;

  // v1 gates the second-stage capture, so a latency-1 operand arriving
  // without an accept in the previous cycle leaves the datapath untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      op_count <= 16'd0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (v2) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

  assign out_valid = v2;

  for (genvar l = 0; l < W; l++) begin : g_lane
    msk_and_hpc2_lane #(
      .d     (d),
      .CROSS (CROSS)
    ) u_lane (
      .clk (clk),
      .en0 (accept),
      .en1 (v1),
      .x   (op_x[share_base(l, d) +: d]),
      .y   (op_y[share_base(l, d) +: d]),
      .r   (rnd[rnd_base(l, d) +: R]),
      .out (out[share_base(l, d) +: d])
    );
  end

endmodule

// File: tb/tb_msk_and_hpc2_bus.sv
// tb_msk_and_hpc2_bus: self-checking bench for msk_and_hpc2_bus.
// dut_a: d=2, W=8, SWAP=0, CROSS=0. dut_b: d=3, W=8, SWAP=1, CROSS=1.
module tb_msk_and_hpc2_bus;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic        in_valid_a, in_ready_a, rnd_valid_a, out_valid_a;
  logic [15:0] ina_a, inb_a, out_a, op_count_a;
  logic [7:0]  rnd_a;

  msk_and_hpc2_bus #(.d(2), .W(W), .SWAP(0), .CROSS(0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .ina       (ina_a),
    .inb       (inb_a),
    .rnd       (rnd_a),
    .rnd_valid (rnd_valid_a),
    .out       (out_a),
    .out_valid (out_valid_a),
    .op_count  (op_count_a)
  );

  // ---------------- DUT B ----------------
  logic        in_valid_b, in_ready_b, rnd_valid_b, out_valid_b;
  logic [23:0] ina_b, inb_b, out_b, rnd_b;
  logic [15:0] op_count_b;

  msk_and_hpc2_bus #(.d(3), .W(W), .SWAP(1), .CROSS(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .ina       (ina_b),
    .inb       (inb_b),
    .rnd       (rnd_b),
    .rnd_valid (rnd_valid_b),
    .out       (out_b),
    .out_valid (out_valid_b),
    .op_count  (op_count_b)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_qa[$];
  logic [7:0]  exp_qb[$];
  logic [7:0]  sa[$], sb[$], se[$];
  logic [7:0]  ta[$], tbq[$];
  logic [15:0] exp_count_a, exp_count_b;
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- sharing helpers ----------------
  function automatic logic [23:0] mask_v(input logic [7:0] v, input int nd);
    logic [23:0] m;
    logic        acc;
    logic        s;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      acc = v[i];
      for (int j = 0; j < nd - 1; j++) begin
        s = 1'($urandom_range(0, 1));
        m[i*nd+j] = s;
        acc = acc ^ s;
      end
      m[i*nd+nd-1] = acc;
    end
    return m;
  endfunction

  function automatic logic [7:0] unmask_v(input logic [23:0] m, input int nd);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < nd; j++) begin
        v[i] = v[i] ^ m[i*nd+j];
      end
    end
    return v;
  endfunction

  // (a AND b) XOR (XOR over j of a_j AND b_j), 3 shares per lane.
  function automatic logic [7:0] cross_exp(input logic [23:0] ma, input logic [23:0] mb);
    logic [7:0] e;
    e = unmask_v(ma, 3) & unmask_v(mb, 3);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        e[i] = e[i] ^ (ma[i*3+j] & mb[i*3+j]);
      end
    end
    return e;
  endfunction

  // ---------------- output monitors ----------------
  always @(negedge clk) begin
    if (out_valid_a === 1'b1) begin
      if (exp_qa.size() == 0) check("a_unexpected_valid", 32'(out_valid_a), 32'd0);
      else check("a_data", 32'(unmask_v({8'h00, out_a}, 2)), 32'(exp_qa.pop_front()));
    end
    if (out_valid_b === 1'b1) begin
      if (exp_qb.size() == 0) check("b_unexpected_valid", 32'(out_valid_b), 32'd0);
      else check("b_data", 32'(unmask_v(out_b, 3)), 32'(exp_qb.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid_a  = 1'b0;
    rnd_valid_a = 1'b0;
    ina_a       = 16'($urandom);
    inb_a       = 16'($urandom);
    rnd_a       = 8'($urandom);
    in_valid_b  = 1'b0;
    rnd_valid_b = 1'b0;
    ina_b       = 24'($urandom);
    inb_b       = 24'($urandom);
    rnd_b       = 24'($urandom);
  endtask

  // Back-to-back stream on dut_a from sa/sb with expectations se.
  task automatic run_stream_a();
    int          n;
    logic [23:0] m;
    n = sa.size();
    for (int k = 0; k < n + 2; k++) begin
      @(posedge clk); #1;
      if (k < n) begin
        m           = mask_v(sa[k], 2);
        ina_a       = m[15:0];
        in_valid_a  = 1'b1;
        rnd_valid_a = 1'b1;
        exp_qa.push_back(se[k]);
      end else begin
        ina_a       = 16'($urandom);
        in_valid_a  = 1'b0;
        rnd_valid_a = 1'b0;
      end
      if (k >= 1 && k <= n) begin
        m     = mask_v(sb[k-1], 2);
        inb_a = m[15:0];
      end else begin
        inb_a = 16'($urandom);
      end
      rnd_a = 8'($urandom);
      @(negedge clk);
      check("a_stream_valid", 32'(out_valid_a), (k >= 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    inb_a = 16'($urandom);
    @(negedge clk);
    exp_count_a = exp_count_a + 16'(n);
    check("a_op_count", 32'(op_count_a), 32'(exp_count_a));
    check("a_drain_valid", 32'(out_valid_a), 32'd0);
    sa.delete();
    sb.delete();
    se.delete();
  endtask

  // Stream on dut_b: inb (latency 0) from tbq, ina (latency 1) from ta.
  task automatic run_stream_b();
    int          n;
    logic [23:0] ma_pend, ma, mb;
    n       = tbq.size();
    ma_pend = '0;
    for (int k = 0; k < n + 2; k++) begin
      @(posedge clk); #1;
      if (k >= 1 && k <= n) ina_b = ma_pend;
      else ina_b = 24'($urandom);
      if (k < n) begin
        mb          = mask_v(tbq[k], 3);
        ma          = mask_v(ta[k], 3);
        inb_b       = mb;
        in_valid_b  = 1'b1;
        rnd_valid_b = 1'b1;
        exp_qb.push_back(cross_exp(ma, mb));
        ma_pend     = ma;
      end else begin
        inb_b       = 24'($urandom);
        in_valid_b  = 1'b0;
        rnd_valid_b = 1'b0;
      end
      rnd_b = 24'($urandom);
      @(negedge clk);
      check("b_stream_valid", 32'(out_valid_b), (k >= 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    ina_b = 24'($urandom);
    @(negedge clk);
    exp_count_b = exp_count_b + 16'(n);
    check("b_op_count", 32'(op_count_b), 32'(exp_count_b));
    ta.delete();
    tbq.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [7:0]  ra, rb;
  logic [23:0] mm;

  initial begin
    vecs[0] = '{a: 8'hF0, b: 8'h3C, y: 8'h30};
    vecs[1] = '{a: 8'h00, b: 8'hFF, y: 8'h00};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, y: 8'hFF};
    vecs[3] = '{a: 8'hAA, b: 8'h55, y: 8'h00};
    vecs[4] = '{a: 8'h0F, b: 8'h0F, y: 8'h0F};
    vecs[5] = '{a: 8'hA5, b: 8'h3C, y: 8'h24};
    vecs[6] = '{a: 8'h81, b: 8'hC3, y: 8'h81};
    vecs[7] = '{a: 8'h5A, b: 8'hF0, y: 8'h50};
    exp_count_a = 16'd0;
    exp_count_b = 16'd0;

    // Reset with requests and randomness offered: nothing may be accepted.
    idle_inputs();
    rst         = 1'b1;
    in_valid_a  = 1'b1;
    rnd_valid_a = 1'b1;
    in_valid_b  = 1'b1;
    rnd_valid_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready_a", 32'(in_ready_a), 32'd0);
    end
    check("rst_in_ready_b", 32'(in_ready_b), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_out_valid_a", 32'(out_valid_a), 32'd0);
    check("rst_op_count_a", 32'(op_count_a), 32'd0);
    check("rst_out_valid_b", 32'(out_valid_b), 32'd0);
    check("rst_op_count_b", 32'(op_count_b), 32'd0);
    repeat (2) @(negedge clk);

    // Single full product 0xF0 & 0x3C.
    sa.push_back(8'hF0); sb.push_back(8'h3C); se.push_back(8'h30);
    run_stream_a();

    // Table vectors, streamed back to back.
    for (int i = 0; i < 8; i++) begin
      sa.push_back(vecs[i].a);
      sb.push_back(vecs[i].b);
      se.push_back(vecs[i].y);
    end
    run_stream_a();

    // 100 random consecutive accepts.
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      sa.push_back(ra); sb.push_back(rb); se.push_back(ra & rb);
    end
    run_stream_a();

    // Starvation: requests without randomness are refused.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid_a  = 1'b1;
      rnd_valid_a = 1'b0;
      ina_a       = 16'($urandom);
      inb_a       = 16'($urandom);
      @(negedge clk);
      check("starve_in_ready", 32'(in_ready_a), 32'd0);
      check("starve_out_valid", 32'(out_valid_a), 32'd0);
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("starve_op_count", 32'(op_count_a), 32'(exp_count_a));
    check("starve_out_valid_after", 32'(out_valid_a), 32'd0);

    // SWAP=1, CROSS=1, d=3: inb 0xFF at t, ina 0xAA at t+1, then random ops.
    tbq.push_back(8'hFF); ta.push_back(8'hAA);
    for (int i = 0; i < 20; i++) begin
      tbq.push_back(8'($urandom_range(0, 255)));
      ta.push_back(8'($urandom_range(0, 255)));
    end
    run_stream_b();

    // Reset one cycle after an accept: the operation must vanish.
    @(posedge clk); #1;
    mm          = mask_v(8'hF0, 2);
    ina_a       = mm[15:0];
    in_valid_a  = 1'b1;
    rnd_valid_a = 1'b1;
    rnd_a       = 8'($urandom);
    @(posedge clk); #1;
    mm          = mask_v(8'h3C, 2);
    inb_a       = mm[15:0];
    in_valid_a  = 1'b0;
    rnd_valid_a = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    check("rst_flight_in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_flight_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_flight_op_count", 32'(op_count_a), 32'd0);
    exp_count_a = 16'd0;
    exp_count_b = 16'd0;
    repeat (3) begin
      @(negedge clk);
      check("rst_flight_quiet", 32'(out_valid_a), 32'd0);
    end

    // Counter wrap: 0xFFFF results, then one more.
    for (int i = 0; i < 65535; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      sa.push_back(ra); sb.push_back(rb); se.push_back(ra & rb);
    end
    run_stream_a();
    check("wrap_at_ffff", 32'(op_count_a), 32'h0000FFFF);
    sa.push_back(8'h3C); sb.push_back(8'hC3); se.push_back(8'h00);
    run_stream_a();
    check("wrap_to_zero", 32'(op_count_a), 32'd0);

    repeat (3) @(negedge clk);
    check("a_queue_empty", 32'(exp_qa.size()), 32'd0);
    check("b_queue_empty", 32'(exp_qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msk_and_hpc2_bus.md
MSK_AND_HPC2_BUS -- requirements
Module: msk_and_hpc2_bus

Interface
REQ-001 Parameter d, default 2: number of shares per bit; legal range 2..8.
REQ-002 Parameter W, default 8: number of independent masked bits (lanes) processed in parallel; legal range 1..128.
REQ-003 Parameter SWAP, default 0: 0 = ina at latency 0 and inb at latency 1; 1 = roles of ina/inb exchanged at the port level.
REQ-004 Parameter CROSS, default 0: 0 = full HPC2 product; 1 = cross-domain terms only, inner-domain products omitted.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 in_valid  input  1  ina sharing presented this cycle.
REQ-008 in_ready  output  1  block accepts a new operation this cycle.
REQ-009 ina  input  W*d  first operand, lane-major: bit i share j at index i*d+j.
REQ-010 inb  input  W*d  second operand, same layout, presented exactly one cycle after the accepted ina.
REQ-011 rnd  input  W*hpc2rnd  fresh randomness, hpc2rnd = d*(d-1)/2 bits per lane, consumed in the accept cycle.
REQ-012 rnd_valid  input  1  rnd holds fresh, unused randomness this cycle.
REQ-013 out  output  W*d  result sharing, same layout.
REQ-014 out_valid  output  1  out holds a valid result this cycle.
REQ-015 op_count  output  16  number of results delivered since reset.

Function
REQ-016 Accept occurs in the cycle where in_valid, in_ready and not rst are all high.
REQ-017 in_ready equals rnd_valid; no operation is accepted without fresh randomness.
REQ-018 Latency: if accept is at cycle t, inb is sampled at t+1 and out/out_valid are presented at t+2.
REQ-019 Throughput: one accept per cycle; back-to-back accepts produce back-to-back results without stalls.
REQ-020 Each lane implements HPC2: in cycle t, register rnd-masked cross terms using the latency-0 operand; in cycle t+1, combine with the latency-1 operand; in cycle t+2, output share XOR.
REQ-021 CROSS=0: unmasked out equals unmasked (ina AND inb), bitwise per lane.
REQ-022 CROSS=1: unmasked out equals (a AND b) XOR (XOR over j of a_j AND b_j), bitwise per lane.
REQ-023 SWAP=1: inb is sampled at t and ina at t+1; everything else is identical.
REQ-024 No rnd bit is used in more than one operation or in more than one lane.
REQ-025 A two-stage valid shift register tracks in-flight operations; out_valid is its final stage.
REQ-026 out is don't-care when out_valid is low; no share recombination occurs anywhere in the datapath.
REQ-027 op_count increments by 1 in every cycle where out_valid is high, and wraps from 0xFFFF to 0x0000.
REQ-028 inb presented in a cycle without an accept one cycle earlier is ignored.

Reset
REQ-029 While rst is high: valid stages, out_valid and op_count are cleared at the next edge, and in_ready is forced low.
REQ-030 rst asserted mid-operation discards all in-flight operations; none produces out_valid after reset is released.
REQ-031 Share and randomness registers are not reset, so no reset value is imposed on masked data.

Structure
REQ-032 Shared package/header msk_pkg holds the hpc2rnd(d) function and the lane index helpers.
REQ-033 Sub-module msk_and_hpc2_lane implements one d-share lane and carries the CROSS parameter; the top instantiates W lanes, performs the SWAP port exchange, and owns the valid pipeline and counter.
REQ-034 Registers on the gadget paths are kept with fv/keep attributes so that synthesis does not merge or flatten them across lanes.

Verification
REQ-035 Full product: d=2, W=8, CROSS=0, ina unmasks to 0xF0 at t, inb unmasks to 0x3C at t+1, random rnd -> out unmasks to 0x30 and out_valid=1 at t+2.
REQ-036 Stream: 100 consecutive random accepts -> 100 consecutive out_valid cycles, each correct, and op_count=100.
REQ-037 Starvation: rnd_valid=0 with in_valid=1 for 5 cycles -> in_ready=0, no out_valid, op_count unchanged.
REQ-038 Reset mid-flight: rst asserted at t+1 after accept -> out_valid=0 at t+2 and op_count=0.
REQ-039 SWAP=1 and CROSS=1, d=3: inb unmasks to 0xFF at t, ina unmasks to 0xAA at t+1 -> out matches REQ-022 per lane.
REQ-040 Wrap and security: preload 0xFFFF results -> next result gives op_count=0x0000; a d=2 netlist passes first-order probing/PINI formal check.
